frq_meter: RTL



---
 rtl/frq_pkg.sv | 16 +
 rtl/frq_sync_edge.sv | 25 ++
 rtl/frq_meter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/frq_pkg.sv
// Shared definitions for frq_meter: divider period table, FSM state type, select width.
package frq_pkg;

    localparam int FSEL_W = 5;

    typedef enum logic [1:0] {IDLE, MEASURE, SEARCH} state_t;

    // Expected divider output period per select code: entry i = 2*(i+1). Needs CNT_W >= 7.
    localparam logic [6:0] DIV_TABLE [0:31] = '{
        7'd2,  7'd4,  7'd6,  7'd8,  7'd10, 7'd12, 7'd14, 7'd16,
        7'd18, 7'd20, 7'd22, 7'd24, 7'd26, 7'd28, 7'd30, 7'd32,
        7'd34, 7'd36, 7'd38, 7'd40, 7'd42, 7'd44, 7'd46, 7'd48,
        7'd50, 7'd52, 7'd54, 7'd56, 7'd58, 7'd60, 7'd62, 7'd64
    };

endpackage

// File: rtl/frq_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector (3-cycle latency).
module frq_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/frq_meter.sv
// Period meter: counts clk cycles between sig_in rising edges and decodes the select code.
// Define FRQ_METER_AVG_EN to average four consecutive periods before each table search.
module frq_meter
    import frq_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TOL   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  period,
    output logic [FSEL_W-1:0] f_sel,
    output logic              match,
    output logic              valid,
    output logic              timeout
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FSEL_W-1:0] IDX_LAST = '1;

    state_t             state, state_nx;
    logic               rise;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CNT_W-1:0]   period_q, period_q_nx, period_nx;
    logic [FSEL_W-1:0]  idx, idx_nx, f_sel_nx;
    logic               match_nx, valid_nx, timeout_nx;
    logic [CNT_W:0]     diff, abs_diff;
    logic               hit;
`ifdef FRQ_METER_AVG_EN
    logic [CNT_W+1:0]   acc, acc_nx, acc_sum;
    logic [1:0]         phase, phase_nx;
`endif

    frq_sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sig_in),
        .rise    (rise)
    );

    // One extra bit keeps the subtraction sign-safe for either ordering.
    always_comb begin
        diff     = {1'b0, period_q} - (CNT_W+1)'(DIV_TABLE[idx]);
        abs_diff = diff[CNT_W] ? -diff : diff;
        hit      = (abs_diff <= (CNT_W+1)'(TOL));
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        period_q_nx = period_q;
        idx_nx      = idx;
        period_nx   = period;
        f_sel_nx    = f_sel;
        match_nx    = match;
        valid_nx    = 1'b0;
        timeout_nx  = timeout;
`ifdef FRQ_METER_AVG_EN
        acc_nx      = acc;
        phase_nx    = phase;
        acc_sum     = acc + {2'b00, cnt};
`endif
        if (rise) timeout_nx = 1'b0;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rise) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    cnt_nx = CNT_ONE;
`ifdef FRQ_METER_AVG_EN
                    if (phase == 2'd3) begin
                        period_q_nx = acc_sum[CNT_W+1:2];
                        acc_nx      = '0;
                        phase_nx    = '0;
                        idx_nx      = '0;
                        state_nx    = SEARCH;
                    end else begin
                        acc_nx   = acc_sum;
                        phase_nx = phase + 2'd1;
                    end
`else
                    period_q_nx = cnt;
                    idx_nx      = '0;
                    state_nx    = SEARCH;
`endif
                end else if (cnt == '1) begin
                    cnt_nx     = '0;
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
`ifdef FRQ_METER_AVG_EN
                    acc_nx     = '0;
                    phase_nx   = '0;
`endif
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            SEARCH: begin
                // The counter keeps timing the next period; an edge here restarts it unlatched.
                if (rise)            cnt_nx = CNT_ONE;
                else if (cnt != '1)  cnt_nx = cnt + CNT_ONE;

                if (hit || idx == IDX_LAST) begin
                    f_sel_nx  = hit ? idx : '0;
                    match_nx  = hit;
                    period_nx = period_q;
                    valid_nx  = 1'b1;
                    state_nx  = MEASURE;
                end else begin
                    idx_nx = idx + 5'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            period_q <= '0;
            idx      <= '0;
            period   <= '0;
            f_sel    <= '0;
            match    <= 1'b0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
`ifdef FRQ_METER_AVG_EN
            acc      <= '0;
            phase    <= '0;
`endif
        end else begin
            cnt      <= cnt_nx;
            period_q <= period_q_nx;
            idx      <= idx_nx;
            period   <= period_nx;
            f_sel    <= f_sel_nx;
            match    <= match_nx;
            valid    <= valid_nx;
            timeout  <= timeout_nx;
`ifdef FRQ_METER_AVG_EN
            acc      <= acc_nx;
            phase    <= phase_nx;
`endif
        end
    end

endmodule
